// File: rtl/spatz_tcdm_rsp_adapter.sv
// rtl/spatz_tcdm_rsp_adapter.sv - decoupled TCDM port to fixed-latency shim adapter with credit-gated response buffer
module spatz_tcdm_rsp_adapter #(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned CoreIDWidth  = 1,
    parameter int unsigned RspDepth     = 2,
    parameter int unsigned StrbWidth    = DataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrMemWidth-1:0] req_addr_i,
    input  logic [3:0]              req_amo_i,
    input  logic                    req_write_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [StrbWidth-1:0]    req_wstrb_i,
    input  logic [CoreIDWidth-1:0]  req_core_id_i,
    input  logic                    req_is_core_i,
    input  logic                    req_dma_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DataWidth-1:0]    rsp_rdata_o,
    output logic                    rsp_write_o,
    output logic                    shim_valid_o,
    input  logic                    shim_ready_i,
    output logic                    shim_dma_o,
    output logic [AddrMemWidth-1:0] shim_addr_o,
    output logic [3:0]              shim_amo_o,
    output logic                    shim_write_o,
    output logic [DataWidth-1:0]    shim_wdata_o,
    output logic [StrbWidth-1:0]    shim_wstrb_o,
    output logic [CoreIDWidth-1:0]  shim_core_id_o,
    output logic                    shim_is_core_o,
    input  logic [DataWidth-1:0]    shim_rdata_i
);

    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = $clog2(RspDepth);
    localparam logic [CntWidth:0]   DepthW  = (CntWidth + 1)'(RspDepth);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(RspDepth);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(RspDepth - 1);

    if (RspDepth < 2 || !(DataWidth == 32 || DataWidth == 64) || StrbWidth != DataWidth / 8) begin : g_param_check
        $error("spatz_tcdm_rsp_adapter: illegal parameterisation");
    end

    logic [DataWidth-1:0] buf_data_q [RspDepth];
    logic [RspDepth-1:0]  buf_wr_q;
    logic [PtrWidth-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic                 inflight_q, inflight_wr_q;
    logic [CntWidth:0]    outstanding;
    logic                 credit_ok, fire, buf_empty, push, pop, pop_buf;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Credits count buffered beats plus the beat still on its way from the shim.
    assign outstanding = {1'b0, count_q} + {{CntWidth{1'b0}}, inflight_q};
    assign credit_ok   = outstanding < DepthW;

    assign req_ready_o    = shim_ready_i & credit_ok;
    assign shim_valid_o   = req_valid_i & credit_ok;
    assign fire           = req_valid_i & req_ready_o;
    assign shim_dma_o     = req_dma_i;
    assign shim_addr_o    = req_addr_i;
    assign shim_amo_o     = req_amo_i;
    assign shim_write_o   = req_write_i;
    assign shim_wdata_o   = req_wdata_i;
    assign shim_wstrb_o   = req_wstrb_i;
    assign shim_core_id_o = req_core_id_i;
    assign shim_is_core_o = req_is_core_i;

    assign buf_empty   = (count_q == '0);
    assign rsp_valid_o = ~buf_empty | inflight_q;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign pop_buf     = pop & ~buf_empty;
    // A fresh beat goes into the buffer unless it can bypass straight out.
    assign push        = inflight_q & (~buf_empty | ~rsp_ready_i);

    always_comb begin
        rsp_rdata_o = '0;
        rsp_write_o = 1'b0;
        if (!buf_empty) begin
            rsp_rdata_o = buf_data_q[head_q];
            rsp_write_o = buf_wr_q[head_q];
        end else if (inflight_q) begin
            rsp_rdata_o = shim_rdata_i;
            rsp_write_o = inflight_wr_q;
        end
    end

    always_comb begin
        head_d  = pop_buf ? next_ptr(head_q) : head_q;
        tail_d  = push ? next_ptr(tail_q) : tail_q;
        count_d = count_q;
        case ({push, pop_buf})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_wr_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= fire;
            if (fire) begin
                inflight_wr_q <= req_write_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_data_q[tail_q] <= shim_rdata_i;
            buf_wr_q[tail_q]   <= inflight_wr_q;
        end
    end

    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && count_q == FullCnt));
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_buf && buf_empty) && !(pop && !rsp_valid_o));

endmodule

// File: tb/tb_spatz_tcdm_rsp_adapter.sv
// tb/tb_spatz_tcdm_rsp_adapter.sv - table-driven bench for spatz_tcdm_rsp_adapter
module tb_spatz_tcdm_rsp_adapter;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic        wr;
        logic [3:0]  amo;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        rsp_rdy;
        logic        shim_rdy;
        logic        chk;
        logic        e_req_rdy;
        logic        e_shim_vld;
        logic        e_rsp_vld;
        logic [63:0] e_rdata;
        logic        e_rsp_wr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_is_core, req_dma;
    logic [31:0] req_addr;
    logic [3:0]  req_amo;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [0:0]  req_core_id;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [63:0] rsp_rdata;
    logic        shim_valid, shim_ready, shim_dma, shim_write, shim_is_core;
    logic [31:0] shim_addr;
    logic [3:0]  shim_amo;
    logic [63:0] shim_wdata, shim_rdata;
    logic [7:0]  shim_wstrb;
    logic [0:0]  shim_core_id;

    logic        d3_vld, d3_req_rdy, d3_rsp_vld, d3_rsp_rdy, d3_rsp_wr;
    logic        d3_shim_vld, d3_shim_rdy, d3_shim_dma, d3_shim_wr, d3_shim_is_core;
    logic [31:0] d3_addr, d3_shim_addr;
    logic [3:0]  d3_shim_amo;
    logic [63:0] d3_rdata, d3_shim_wdata, d3_shim_rdata;
    logic [7:0]  d3_shim_wstrb;
    logic [0:0]  d3_shim_cid;

    logic [63:0] mem [0:255];
    vec_t        tv[$];
    int          checks = 0;
    int          errors = 0;

    spatz_tcdm_rsp_adapter #(.AddrMemWidth(32), .DataWidth(64), .CoreIDWidth(1), .RspDepth(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_amo_i(req_amo), .req_write_i(req_write), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .req_core_id_i(req_core_id), .req_is_core_i(req_is_core),
        .req_dma_i(req_dma),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_write_o(rsp_write),
        .shim_valid_o(shim_valid), .shim_ready_i(shim_ready), .shim_dma_o(shim_dma),
        .shim_addr_o(shim_addr), .shim_amo_o(shim_amo), .shim_write_o(shim_write),
        .shim_wdata_o(shim_wdata), .shim_wstrb_o(shim_wstrb), .shim_core_id_o(shim_core_id),
        .shim_is_core_o(shim_is_core), .shim_rdata_i(shim_rdata)
    );

    spatz_tcdm_rsp_adapter #(.AddrMemWidth(32), .DataWidth(64), .CoreIDWidth(1), .RspDepth(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(d3_vld), .req_ready_o(d3_req_rdy), .req_addr_i(d3_addr),
        .req_amo_i(4'h0), .req_write_i(1'b0), .req_wdata_i(64'h0),
        .req_wstrb_i(8'h00), .req_core_id_i(1'b0), .req_is_core_i(1'b0),
        .req_dma_i(1'b1),
        .rsp_valid_o(d3_rsp_vld), .rsp_ready_i(d3_rsp_rdy), .rsp_rdata_o(d3_rdata),
        .rsp_write_o(d3_rsp_wr),
        .shim_valid_o(d3_shim_vld), .shim_ready_i(d3_shim_rdy), .shim_dma_o(d3_shim_dma),
        .shim_addr_o(d3_shim_addr), .shim_amo_o(d3_shim_amo), .shim_write_o(d3_shim_wr),
        .shim_wdata_o(d3_shim_wdata), .shim_wstrb_o(d3_shim_wstrb), .shim_core_id_o(d3_shim_cid),
        .shim_is_core_o(d3_shim_is_core), .shim_rdata_i(d3_shim_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shim model: 1-cycle read latency, store returns 0, AMOAdd (code 2) returns old value.
    always @(posedge clk) begin
        if (shim_valid && shim_ready) begin
            if (shim_amo == 4'h2) begin
                shim_rdata            <= mem[shim_addr[7:0]];
                mem[shim_addr[7:0]]   <= mem[shim_addr[7:0]] + shim_wdata;
            end else if (shim_write) begin
                shim_rdata            <= 64'h0;
                mem[shim_addr[7:0]]   <= shim_wdata;
            end else begin
                shim_rdata            <= mem[shim_addr[7:0]];
            end
        end
        if (d3_shim_vld && d3_shim_rdy) begin
            d3_shim_rdata <= {32'hC0DE0000, d3_shim_addr};
        end
    end

    function automatic vec_t mk(input int rst_v, input int vld, input int wr, input int amo,
                                input longint unsigned addr, input longint unsigned wdata,
                                input int rsp_rdy, input int shim_rdy, input int chk,
                                input int e_rr, input int e_sv, input int e_rv,
                                input longint unsigned e_rd, input int e_rw);
        vec_t v;
        v.rst_n = (rst_v != 0);   v.vld = (vld != 0);       v.wr = (wr != 0);
        v.amo = amo[3:0];         v.addr = addr[31:0];      v.wdata = wdata;
        v.rsp_rdy = (rsp_rdy != 0); v.shim_rdy = (shim_rdy != 0); v.chk = (chk != 0);
        v.e_req_rdy = (e_rr != 0);  v.e_shim_vld = (e_sv != 0);  v.e_rsp_vld = (e_rv != 0);
        v.e_rdata = e_rd;         v.e_rsp_wr = (e_rw != 0);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx %0d got %0h want %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_amo = 4'h0; req_addr = 32'h0;
        req_wdata = 64'h0; req_wstrb = 8'hFF; req_core_id = 1'b1; req_is_core = 1'b1; req_dma = 1'b0;
        rsp_ready = 1'b1; shim_ready = 1'b1; shim_rdata = 64'h0;
        d3_vld = 1'b0; d3_addr = 32'h0; d3_rsp_rdy = 1'b1; d3_shim_rdy = 1'b1; d3_shim_rdata = 64'h0;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        mem[8'h10] = 64'h1111; mem[8'h11] = 64'h2222; mem[8'h12] = 64'h3333;
        mem[8'h20] = 64'hAAAA; mem[8'h21] = 64'hBBBB; mem[8'h22] = 64'hCCCC;
        mem[8'h40] = 64'h5;

        //           rst vld wr amo addr   wdata        rr sr  chk rr sv rv rdata          rw
        tv.push_back(mk(0, 0, 0, 0, 0,     0,           1, 1,  0,  1, 0, 0, 0,             0));
        tv.push_back(mk(0, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h10,  0,           1, 1,  1,  1, 1, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h11,  0,           1, 1,  1,  1, 1, 1, 'h1111,        0));
        tv.push_back(mk(1, 1, 0, 0, 'h12,  0,           1, 1,  1,  1, 1, 1, 'h2222,        0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 1, 'h3333,        0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h20,  0,           0, 1,  1,  1, 1, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h21,  0,           0, 1,  1,  1, 1, 1, 'hAAAA,        0));
        tv.push_back(mk(1, 1, 0, 0, 'h22,  0,           0, 1,  1,  0, 0, 1, 'hAAAA,        0));
        tv.push_back(mk(1, 1, 0, 0, 'h22,  0,           0, 1,  1,  0, 0, 1, 'hAAAA,        0));
        tv.push_back(mk(1, 1, 0, 0, 'h22,  0,           0, 1,  1,  0, 0, 1, 'hAAAA,        0));
        tv.push_back(mk(1, 1, 0, 0, 'h22,  0,           1, 1,  1,  0, 0, 1, 'hAAAA,        0));
        tv.push_back(mk(1, 1, 0, 0, 'h22,  0,           1, 1,  1,  1, 1, 1, 'hBBBB,        0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 1, 'hCCCC,        0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 0, 0,             0));
        tv.push_back(mk(1, 1, 1, 0, 'h30,  'hDEADBEEF,  1, 1,  1,  1, 1, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h30,  0,           1, 1,  1,  1, 1, 1, 0,             1));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 1, 'hDEADBEEF,    0));
        tv.push_back(mk(1, 1, 0, 2, 'h40,  3,           1, 1,  1,  1, 1, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h40,  0,           1, 0,  1,  0, 1, 1, 5,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h40,  0,           1, 0,  1,  0, 1, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h40,  0,           1, 1,  1,  1, 1, 0, 0,             0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 1, 8,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h10,  0,           0, 1,  1,  1, 1, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h11,  0,           0, 1,  1,  1, 1, 1, 'h1111,        0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           0, 1,  1,  0, 0, 1, 'h1111,        0));
        tv.push_back(mk(0, 0, 0, 0, 0,     0,           0, 1,  1,  0, 0, 1, 'h1111,        0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 0, 0,             0));
        tv.push_back(mk(1, 1, 0, 0, 'h12,  0,           1, 1,  1,  1, 1, 0, 0,             0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 1, 'h3333,        0));
        tv.push_back(mk(1, 0, 0, 0, 0,     0,           1, 1,  1,  1, 0, 0, 0,             0));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n; req_valid = tv[i].vld; req_write = tv[i].wr; req_amo = tv[i].amo;
            req_addr = tv[i].addr; req_wdata = tv[i].wdata; rsp_ready = tv[i].rsp_rdy;
            shim_ready = tv[i].shim_rdy;
            #2;
            if (tv[i].chk) begin
                chk("req_ready", i, {127'h0, req_ready}, {127'h0, tv[i].e_req_rdy});
                chk("shim_valid", i, {127'h0, shim_valid}, {127'h0, tv[i].e_shim_vld});
                chk("rsp_valid", i, {127'h0, rsp_valid}, {127'h0, tv[i].e_rsp_vld});
                chk("rsp_rdata", i, {64'h0, rsp_rdata}, {64'h0, tv[i].e_rdata});
                chk("rsp_write", i, {127'h0, rsp_write}, {127'h0, tv[i].e_rsp_wr});
                chk("shim_req", i, {27'h0, shim_addr, shim_amo, shim_write, shim_wdata},
                    {27'h0, tv[i].addr, tv[i].amo, tv[i].wr, tv[i].wdata});
            end
        end
        chk("shim_side", 0, {116'h0, shim_wstrb, shim_core_id, shim_is_core, shim_dma},
            {116'h0, 8'hFF, 1'b1, 1'b1, 1'b0});

        // Depth-3 instance, DMA reads: one beat parked, then push and pop together every cycle.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            d3_vld = (k < 12);
            d3_addr = 32'h100 + k;
            d3_rsp_rdy = (k >= 2);
            #2;
            if (k < 12) begin
                chk("d3_req_ready", k, {127'h0, d3_req_rdy}, {127'h0, 1'b1});
                chk("d3_shim_dma", k, {127'h0, d3_shim_dma}, {127'h0, 1'b1});
            end
            if (k == 0 || k == 14) begin
                chk("d3_rsp_valid", k, {127'h0, d3_rsp_vld}, {127'h0, 1'b0});
            end else begin
                chk("d3_rsp_valid", k, {127'h0, d3_rsp_vld}, {127'h0, 1'b1});
                chk("d3_rsp_rdata", k, {64'h0, d3_rdata},
                    {64'h0, 32'hC0DE0000, 32'h100 + ((k == 1) ? 0 : k - 2)});
                chk("d3_rsp_write", k, {127'h0, d3_rsp_wr}, {127'h0, 1'b0});
            end
        end
        chk("d3_passthru", 0, {49'h0, d3_shim_amo, d3_shim_wr, d3_shim_wdata, d3_shim_wstrb, d3_shim_cid, d3_shim_is_core},
            {49'h0, 4'h0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
